ar_mux_scan: RTL and testbench
==============================

Name: ar_mux_scan

Overview:
Parameterised successor to the fixed 8-entry, 8-bit array multiplexer. It holds a writable register array of DEPTH x WIDTH entries. It returns one entry per read, either by direct select or by an autonomous scan that sweeps every entry in order. The output is registered and qualified by a valid strobe, so it can feed downstream registered logic or bench monitors directly.

Parameters:
WIDTH, 8, data width of each array entry and of q
DEPTH, 8, number of array entries; legal range 2..2**SEL_W
SEL_W, 3, width of select/address buses

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe
wr_addr  in  SEL_W  write address
wr_data  in  WIDTH  write data
rd_en  in  1  direct-read request (mode=0 only)
rd_sel  in  SEL_W  direct-read select
mode  in  1  0 = direct select, 1 = scan
scan_start  in  1  start a scan (mode=1, IDLE only)
q  out  WIDTH  registered selected entry
q_valid  out  1  q holds a fresh result this cycle
cur_sel  out  SEL_W  index of the entry currently driving q
scan_busy  out  1  high while in SCAN
scan_done  out  1  one-cycle pulse after the last scan entry

Behaviour:
- Reset (rst_n=0, asynchronous, immediate):
  - array entry i = i, zero-extended or truncated to WIDTH
  - q=0, q_valid=0, cur_sel=0, scan_busy=0, scan_done=0, FSM=IDLE, scan counter=0
- Reset asserted mid-scan aborts the scan at once; no scan_done is produced.
- Write:
  - wr_en=1 and wr_addr<DEPTH: array[wr_addr] <= wr_data at the edge.
  - wr_addr>=DEPTH: the write is dropped silently.
  - Writes are legal in every state and mode.
- Read-during-write: if a read (direct or scan) targets the address being written in the same cycle, q takes wr_data (write-first bypass).
- Direct mode (mode=0, FSM=IDLE):
  - rd_en=1 at edge N gives q=array[rd_sel], cur_sel=rd_sel, q_valid=1 after edge N (latency 1).
  - rd_sel>=DEPTH gives q=0 and q_valid=1.
  - rd_en=0: q holds its last value, q_valid=0.
- Scan FSM, states IDLE, SCAN, DONE:
  - IDLE -> SCAN when mode=1 and scan_start=1; counter <= 0.
  - In SCAN, each cycle: q <= array[counter], cur_sel <= counter, q_valid=1, counter++.
  - After the entry DEPTH-1 is issued: SCAN -> DONE.
  - DONE: scan_done=1, q_valid=0, q holds; next cycle -> IDLE.
  - One scan therefore gives exactly DEPTH consecutive valid cycles, then 1 done cycle.
- scan_busy=1 exactly while FSM=SCAN.
- scan_start while in SCAN or DONE is ignored; no restart, no queueing.
- rd_en is ignored while mode=1 or while FSM is not IDLE.
- mode dropping to 0 during SCAN aborts the scan:
  - FSM -> IDLE next edge, q_valid=0 that cycle, no scan_done.
  - The counter does not persist into the next scan; a new scan starts at 0.
- Scan reads see in-flight writes: bypass rule above; later entries see earlier writes.
- cur_sel and q only change on a valid read cycle.

Test Plan:
- Reset, then mode=0, rd_en with rd_sel=0..7 one per cycle -> q=0,1,...,7 each one cycle later, q_valid=1 each cycle; rd_en=0 afterwards -> q_valid=0, q=7 held.
- Write 8'hA5 to addr 3, then read sel 3 -> q=8'hA5. Read sel 3 in the same cycle as a write of 8'h3C to addr 3 -> q=8'h3C (bypass).
- mode=1, one-cycle scan_start -> scan_busy high 8 cycles, q=0..7 with cur_sel=0..7, then scan_done=1 for 1 cycle, then IDLE; rd_en pulses issued during the scan produce no extra q_valid.
- Scan aborts:
  - Drop mode to 0 after 3 scan outputs -> q_valid falls next cycle, no scan_done, scan_busy=0.
  - Restart the scan -> it begins at cur_sel=0.
  - Repeat with rst_n pulsed low mid-scan -> all outputs 0 immediately, array restored to i.
- Out of range with DEPTH=5, SEL_W=3:
  - Read sel 6 -> q=0, q_valid=1.
  - Write 8'hFF to addr 7 -> dropped; a full scan still shows 0..4 in exactly 5 valid cycles.
- WIDTH=16, DEPTH=4, SEL_W=2: scan_start asserted continuously -> scans repeat back-to-back as SCAN(4), DONE(1), IDLE(1) per period; q width 16, values 0..3.

Source files
------------

// File: rtl/ar_mux_scan.sv
// ar_mux_scan: DEPTH x WIDTH register array, read by direct select or by an in-order scan,
// with a registered, valid-qualified output and write-first bypass.
module ar_mux_scan #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [SEL_W-1:0] rd_sel,
    input  logic             mode,
    input  logic             scan_start,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [SEL_W-1:0] cur_sel,
    output logic             scan_busy,
    output logic             scan_done
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [SEL_W-1:0] cnt, cnt_nxt, rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic wr_ok, rd_fire;
    assign wr_ok = wr_en && (32'(wr_addr) < DEPTH);
    assign rd_data = (wr_ok && wr_addr == rd_addr) ? wr_data :
                     (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
    assign scan_busy = state == SCAN;
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rd_fire   = 1'b0;
        rd_addr   = rd_sel;
        case (state)
            IDLE: begin
                rd_fire = !mode && rd_en;
                if (mode && scan_start) begin
                    state_nxt = SCAN;
                    cnt_nxt   = '0;
                end
            end
            SCAN: begin
                rd_addr = cnt;
                if (!mode) state_nxt = IDLE;
                else begin
                    rd_fire = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                    if (32'(cnt) == DEPTH - 1) state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
    // scan_done is registered so the done cycle follows the last valid output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            q         <= '0;
            q_valid   <= 1'b0;
            cur_sel   <= '0;
            scan_done <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'(i);
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            q_valid   <= rd_fire;
            scan_done <= state == DONE;
            if (rd_fire) begin
                q       <= rd_data;
                cur_sel <= rd_addr;
            end
            if (wr_ok) mem[wr_addr] <= wr_data;
        end
    end
endmodule

// File: tb/tb_ar_mux_scan.sv
// tb_ar_mux_scan: random and directed checks of ar_mux_scan in three configurations
// against a transaction-level array model.
module tb_ar_mux_scan;
    logic clk = 1'b0, rst_n = 1'b1;
    always #5 clk = ~clk;
    int n_vec = 0, n_err = 0;

    logic a_wr_en, a_rd_en, a_mode, a_start, a_v, a_busy, a_done;
    logic [2:0] a_wr_addr, a_rd_sel, a_cur;
    logic [7:0] a_wr_data, a_q;
    logic b_wr_en, b_rd_en, b_mode, b_start, b_v, b_busy, b_done;
    logic [2:0] b_wr_addr, b_rd_sel, b_cur;
    logic [7:0] b_wr_data, b_q;
    logic c_wr_en, c_rd_en, c_mode, c_start, c_v, c_busy, c_done;
    logic [1:0] c_wr_addr, c_rd_sel, c_cur;
    logic [15:0] c_wr_data, c_q;

    ar_mux_scan #(.WIDTH(8), .DEPTH(8), .SEL_W(3)) u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_sel(a_rd_sel), .mode(a_mode), .scan_start(a_start),
        .q(a_q), .q_valid(a_v), .cur_sel(a_cur), .scan_busy(a_busy), .scan_done(a_done));
    ar_mux_scan #(.WIDTH(8), .DEPTH(5), .SEL_W(3)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_sel(b_rd_sel), .mode(b_mode), .scan_start(b_start),
        .q(b_q), .q_valid(b_v), .cur_sel(b_cur), .scan_busy(b_busy), .scan_done(b_done));
    ar_mux_scan #(.WIDTH(16), .DEPTH(4), .SEL_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .rd_en(c_rd_en), .rd_sel(c_rd_sel), .mode(c_mode), .scan_start(c_start),
        .q(c_q), .q_valid(c_v), .cur_sel(c_cur), .scan_busy(c_busy), .scan_done(c_done));

    int m[8];
    int q_exp, sel_exp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) m[i] = i;
        q_exp = 0;
        sel_exp = 0;
    endtask

    task automatic a_step(input int we, input int wa, input int wd, input int re, input int rs);
        a_mode = 1'b0; a_start = 1'b0;
        a_wr_en = 1'(we); a_wr_addr = 3'(wa); a_wr_data = 8'(wd);
        a_rd_en = 1'(re); a_rd_sel = 3'(rs);
        tick;
        if (re != 0) begin
            q_exp = (we != 0 && wa == rs) ? wd : m[rs];
            sel_exp = rs;
        end
        if (we != 0) m[wa] = wd;
        chk("a_valid", 32'(a_v), re);
        chk("a_q", 32'(a_q), q_exp);
        chk("a_cur", 32'(a_cur), sel_exp);
    endtask

    task automatic a_scan(input int n_out);
        int we, wa, wd;
        a_mode = 1'b1; a_start = 1'b1; a_rd_en = 1'b1; a_wr_en = 1'b0;
        tick;
        chk("a_busy_start", 32'(a_busy), 1);
        chk("a_v_start", 32'(a_v), 0);
        a_start = 1'b0;
        for (int k = 0; k < n_out; k++) begin
            we = int'($urandom_range(1)); wa = int'($urandom_range(7)); wd = int'($urandom_range(255));
            a_wr_en = 1'(we); a_wr_addr = 3'(wa); a_wr_data = 8'(wd); a_rd_sel = 3'($urandom);
            tick;
            q_exp = (we != 0 && wa == k) ? wd : m[k];
            sel_exp = k;
            if (we != 0) m[wa] = wd;
            chk("a_scan_v", 32'(a_v), 1);
            chk("a_scan_q", 32'(a_q), q_exp);
            chk("a_scan_cur", 32'(a_cur), sel_exp);
            chk("a_scan_busy", 32'(a_busy), k < 7 ? 1 : 0);
        end
        a_wr_en = 1'b0; a_rd_en = 1'b0;
        if (n_out < 8) a_mode = 1'b0;
        tick;
        chk("a_end_v", 32'(a_v), 0);
        chk("a_end_done", 32'(a_done), n_out < 8 ? 0 : 1);
        chk("a_end_busy", 32'(a_busy), 0);
        chk("a_end_q", 32'(a_q), q_exp);
        tick;
        chk("a_idle_done", 32'(a_done), 0);
        chk("a_idle_v", 32'(a_v), 0);
        a_mode = 1'b0;
    endtask

    initial begin
        {a_wr_en, a_rd_en, a_mode, a_start, a_wr_addr, a_rd_sel, a_wr_data} = '0;
        {b_wr_en, b_rd_en, b_mode, b_start, b_wr_addr, b_rd_sel, b_wr_data} = '0;
        {c_wr_en, c_rd_en, c_mode, c_start, c_wr_addr, c_rd_sel, c_wr_data} = '0;
        #1;
        do_reset;
        chk("rst_q", 32'(a_q), 0);
        chk("rst_v", 32'(a_v), 0);
        chk("rst_cur", 32'(a_cur), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_done", 32'(a_done), 0);
        for (int i = 0; i < 8; i++) a_step(0, 0, 0, 1, i);
        a_step(0, 0, 0, 0, 0);
        a_step(1, 3, 8'hA5, 0, 0);
        a_step(0, 0, 0, 1, 3);
        a_step(1, 3, 8'h3C, 1, 3);
        a_step(0, 0, 0, 1, 3);
        for (int i = 0; i < 60; i++)
            a_step(int'($urandom_range(1)), int'($urandom_range(7)), int'($urandom_range(255)),
                   int'($urandom_range(1)), int'($urandom_range(7)));
        a_scan(8);
        a_scan(3);
        a_scan(8);
        a_scan(8);
        // reset in the middle of a scan, after a write that must be undone
        a_mode = 1'b1; a_start = 1'b1; a_wr_en = 1'b0;
        tick;
        a_start = 1'b0; a_wr_en = 1'b1; a_wr_addr = 3'd5; a_wr_data = 8'h77;
        tick;
        a_wr_en = 1'b0;
        tick;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_q", 32'(a_q), 0);
        chk("mid_rst_v", 32'(a_v), 0);
        chk("mid_rst_cur", 32'(a_cur), 0);
        chk("mid_rst_busy", 32'(a_busy), 0);
        chk("mid_rst_done", 32'(a_done), 0);
        do_reset;
        for (int i = 0; i < 8; i++) a_step(0, 0, 0, 1, 7 - i);
        chk("post_rst_done", 32'(a_done), 0);

        // DEPTH=5 instance: out-of-range reads and writes
        do_reset;
        b_rd_en = 1'b1; b_rd_sel = 3'd6;
        tick;
        chk("b_oor_v", 32'(b_v), 1);
        chk("b_oor_q", 32'(b_q), 0);
        chk("b_oor_cur", 32'(b_cur), 6);
        b_rd_sel = 3'd7; b_wr_en = 1'b1; b_wr_addr = 3'd7; b_wr_data = 8'hFF;
        tick;
        chk("b_oor_bypass_q", 32'(b_q), 0);
        b_wr_en = 1'b0; b_rd_en = 1'b0; b_mode = 1'b1; b_start = 1'b1;
        tick;
        b_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("b_scan_v", 32'(b_v), 1);
            chk("b_scan_q", 32'(b_q), k);
            chk("b_scan_cur", 32'(b_cur), k);
        end
        tick;
        chk("b_done_v", 32'(b_v), 0);
        chk("b_done", 32'(b_done), 1);
        tick;
        chk("b_idle_done", 32'(b_done), 0);
        b_mode = 1'b0;

        // WIDTH=16, DEPTH=4 instance: continuous scan_start gives a 6-cycle period
        do_reset;
        c_wr_en = 1'b1; c_wr_addr = 2'd2; c_wr_data = 16'hBEEF;
        tick;
        c_wr_en = 1'b0; c_mode = 1'b1; c_start = 1'b1;
        for (int t = 0; t < 18; t++) begin
            int pos;
            pos = t % 6;
            tick;
            chk("c_v", 32'(c_v), (pos >= 1 && pos <= 4) ? 1 : 0);
            chk("c_done", 32'(c_done), pos == 5 ? 1 : 0);
            chk("c_busy", 32'(c_busy), pos <= 3 ? 1 : 0);
            if (pos >= 1 && pos <= 4) chk("c_q", 32'(c_q), pos == 3 ? 32'hBEEF : pos - 1);
        end
        c_mode = 1'b0; c_start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
